parity_mem_sequencer: RTL and testbench

Memory-cycle sequencer for the parity/S-register datapath. It arbitrates between the central processor and the monitor/test port, loads the S (address) register, and strobes the memory. For writes it generates the odd-parity bit; for reads it checks parity on the returned word and latches a sticky parity or timeout alarm together with the failing address. It sits between the requesters and the memory/parity hardware, and is the only block that drives S loads and memory strobes.

---
 rtl/parity_mem_sequencer.sv | 179 +++++++++++++++++
 tb/tb_parity_mem_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_mem_sequencer.sv
// Memory-cycle sequencer: arbitrates CPU / monitor requests, loads the S
// register, strobes memory, generates odd parity on writes and checks it on
// reads, and keeps sticky parity / timeout alarms with the first failing S.
module parity_mem_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic        REQ_CPU,
  input  logic [11:0] ADDR_CPU,
  input  logic        WR_CPU,
  input  logic [14:0] WDATA_CPU,
  input  logic        REQ_MON,
  input  logic [11:0] ADDR_MON,
  input  logic        WR_MON,
  input  logic [14:0] WDATA_MON,
  output logic        GNT_CPU,
  output logic        GNT_MON,
  output logic        DONE_CPU,
  output logic        DONE_MON,
  output logic [11:0] S_OUT,
  output logic        WSG,
  output logic        MEM_STB,
  output logic        MEM_WE,
  output logic [15:0] MEM_WDATA,
  input  logic [15:0] MEM_RDATA,
  input  logic        MEM_RDY,
  output logic [14:0] RDATA,
  output logic        PAR_ALARM,
  output logic        TOUT_ALARM,
  output logic [11:0] ALARM_ADDR,
  input  logic        ALARM_CLR
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD_S, STROBE, CHECK} state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_prio_mon;    // 1: monitor wins a tie on the next arbitration
  logic        r_owner_mon;   // requester of the cycle in flight
  logic [11:0] r_addr;
  logic        r_wr;
  logic [14:0] r_wdata;
  logic [11:0] r_s;
  logic [7:0]  r_cnt;
  logic [14:0] r_rdata;
  logic        r_par_alarm;
  logic        r_tout_alarm;
  logic [11:0] r_alarm_addr;

  logic        w_pick_cpu;
  logic        w_pick_mon;
  logic        w_grant;
  logic        w_strobe_end;
  logic        w_timeout;
  logic        w_par_err;
  logic        w_any_set;

  // Tie-break goes to the requester not served last.
  assign w_pick_cpu = REQ_CPU && (!REQ_MON || !r_prio_mon);
  assign w_pick_mon = REQ_MON && (!REQ_CPU ||  r_prio_mon);
  assign w_grant    = (r_state == IDLE) && (w_pick_cpu || w_pick_mon);

  // Strobe ends on MEM_RDY; a ready in the last allowed cycle still counts as ready.
  assign w_strobe_end = (r_state == STROBE) && (MEM_RDY || (r_cnt == LP_TIMEOUT));
  assign w_timeout    = (r_state == STROBE) && !MEM_RDY && (r_cnt == LP_TIMEOUT);
  // Odd parity over all 16 bits: an even XOR is an error.
  assign w_par_err    = w_strobe_end && !w_timeout && !r_wr && !(^MEM_RDATA);
  assign w_any_set    = w_par_err || w_timeout;

  assign S_OUT      = r_s;
  assign RDATA      = r_rdata;
  assign PAR_ALARM  = r_par_alarm;
  assign TOUT_ALARM = r_tout_alarm;
  assign ALARM_ADDR = r_alarm_addr;

  // State register.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_pick_cpu || w_pick_mon) w_next_state = LOAD_S;
      LOAD_S:  w_next_state = STROBE;
      STROBE:  if (w_strobe_end) w_next_state = CHECK;
      CHECK:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode; the grant is held off while reset is asserted.
  always_comb begin
    GNT_CPU   = 1'b0;
    GNT_MON   = 1'b0;
    DONE_CPU  = 1'b0;
    DONE_MON  = 1'b0;
    WSG       = 1'b0;
    MEM_STB   = 1'b0;
    MEM_WE    = 1'b0;
    MEM_WDATA = 16'h0000;
    case (r_state)
      IDLE: begin
        GNT_CPU = !SIM_RST && w_pick_cpu;
        GNT_MON = !SIM_RST && w_pick_mon;
      end
      LOAD_S: WSG = 1'b1;
      STROBE: begin
        MEM_STB   = 1'b1;
        MEM_WE    = r_wr;
        MEM_WDATA = {~^r_wdata, r_wdata};
      end
      CHECK: begin
        DONE_CPU = !r_owner_mon;
        DONE_MON = r_owner_mon;
      end
      default: ;
    endcase
  end

  // Request capture, S load, strobe counter and read data.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      r_prio_mon  <= 1'b0;
      r_owner_mon <= 1'b0;
      r_addr      <= '0;
      r_wr        <= 1'b0;
      r_wdata     <= '0;
      r_s         <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
    end else begin
      if (w_grant) begin
        r_owner_mon <= w_pick_mon;
        r_prio_mon  <= w_pick_cpu;
        r_addr      <= w_pick_mon ? ADDR_MON  : ADDR_CPU;
        r_wr        <= w_pick_mon ? WR_MON    : WR_CPU;
        r_wdata     <= w_pick_mon ? WDATA_MON : WDATA_CPU;
      end
      if (r_state == LOAD_S) begin
        r_s   <= r_addr;
        r_cnt <= 8'd1;
      end else if ((r_state == STROBE) && !w_strobe_end) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= '0;
      end
      // Read data is valid from the DONE cycle; writes leave it untouched.
      if (w_strobe_end && !r_wr) begin
        r_rdata <= w_timeout ? 15'h0000 : MEM_RDATA[14:0];
      end
    end
  end

  // Sticky alarms: a new alarm beats a simultaneous clear, and ALARM_ADDR
  // only follows S when no earlier alarm is still standing.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      r_par_alarm  <= 1'b0;
      r_tout_alarm <= 1'b0;
      r_alarm_addr <= '0;
    end else if (w_any_set) begin
      if (ALARM_CLR || !(r_par_alarm || r_tout_alarm)) r_alarm_addr <= r_s;
      r_par_alarm  <= (r_par_alarm  && !ALARM_CLR) || w_par_err;
      r_tout_alarm <= (r_tout_alarm && !ALARM_CLR) || w_timeout;
    end else if (ALARM_CLR) begin
      r_par_alarm  <= 1'b0;
      r_tout_alarm <= 1'b0;
      r_alarm_addr <= '0;
    end
  end

endmodule

// File: tb/tb_parity_mem_sequencer.sv
// Scoreboard bench for parity_mem_sequencer: stimulus pushes expected grants,
// strobes and completions; a monitor pops and compares as the DUT shows them.
module tb_parity_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_cpu = 1'b0, wr_cpu = 1'b0, req_mon = 1'b0, wr_mon = 1'b0;
  logic [11:0] addr_cpu = '0, addr_mon = '0;
  logic [14:0] wdata_cpu = '0, wdata_mon = '0;
  logic        gnt_cpu, gnt_mon, done_cpu, done_mon, wsg, mem_stb, mem_we;
  logic [11:0] s_out, alarm_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_rdy;
  logic        rdy_en = 1'b1;
  logic [14:0] rdata;
  logic        par_alarm, tout_alarm;
  logic        alarm_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct { bit mon; int gap; } gnt_t;
  typedef struct { bit mon; logic [14:0] rdata; bit par; bit tout; logic [11:0] aaddr; int stb; int lat; } done_t;
  typedef struct { bit we; logic [15:0] wdata; } wr_t;

  gnt_t  gnt_q[$];
  done_t done_q[$];
  wr_t   wr_q[$];

  assign mem_rdy = mem_stb & rdy_en;

  parity_mem_sequencer #(.TIMEOUT(15)) dut (
    .SIM_CLK(clk), .SIM_RST(rst),
    .REQ_CPU(req_cpu), .ADDR_CPU(addr_cpu), .WR_CPU(wr_cpu), .WDATA_CPU(wdata_cpu),
    .REQ_MON(req_mon), .ADDR_MON(addr_mon), .WR_MON(wr_mon), .WDATA_MON(wdata_mon),
    .GNT_CPU(gnt_cpu), .GNT_MON(gnt_mon), .DONE_CPU(done_cpu), .DONE_MON(done_mon),
    .S_OUT(s_out), .WSG(wsg), .MEM_STB(mem_stb), .MEM_WE(mem_we),
    .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata), .MEM_RDY(mem_rdy),
    .RDATA(rdata), .PAR_ALARM(par_alarm), .TOUT_ALARM(tout_alarm),
    .ALARM_ADDR(alarm_addr), .ALARM_CLR(alarm_clr)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event did not occur", name);
  endtask

  task automatic push_txn(input bit mon, input bit wr, input logic [15:0] exp_wdata, input int gap,
                          input logic [14:0] exp_rdata, input bit par, input bit tout,
                          input logic [11:0] aaddr, input int stb, input int lat);
    gnt_q.push_back('{mon: mon, gap: gap});
    wr_q.push_back('{we: wr, wdata: exp_wdata});
    done_q.push_back('{mon: mon, rdata: exp_rdata, par: par, tout: tout, aaddr: aaddr, stb: stb, lat: lat});
  endtask

  // One cycle: request, wait for grant, optional clear in the strobe cycle, wait for DONE.
  task automatic issue(input bit mon, input logic [11:0] addr, input bit wr, input logic [14:0] wdata,
                       input bit clr_mid, input bit wait_done);
    bit ok;
    @(negedge clk);
    if (mon) begin req_mon = 1'b1; addr_mon = addr; wr_mon = wr; wdata_mon = wdata; end
    else     begin req_cpu = 1'b1; addr_cpu = addr; wr_cpu = wr; wdata_cpu = wdata; end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #4;
      if (mon ? gnt_mon : gnt_cpu) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_cpu = 1'b0;
    req_mon = 1'b0;
    if (!ok) fail_now("grant_wait");
    if (clr_mid) begin
      @(negedge clk); alarm_clr = 1'b1;
      @(negedge clk); alarm_clr = 1'b0;
    end
    if (wait_done) begin
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
        #4;
        if (done_cpu || done_mon) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      if (!ok) fail_now("done_wait");
    end
  endtask

  task automatic clear_alarms();
    @(negedge clk); alarm_clr = 1'b1;
    @(negedge clk); alarm_clr = 1'b0;
    #4;
    check("clr_par", par_alarm, 0);
    check("clr_tout", tout_alarm, 0);
    check("clr_addr", alarm_addr, 0);
  endtask

  // Monitor: samples one time unit before each rising edge.
  initial begin
    int cyc = 0, last_gnt = 0, stb_cnt = 0;
    bit prev_stb = 1'b0;
    gnt_t g; done_t d; wr_t w;
    forever begin
      @(negedge clk); #4;
      cyc++;
      if (gnt_cpu || gnt_mon) begin
        if (gnt_q.size() == 0) fail_now("unexpected_grant");
        else begin
          g = gnt_q.pop_front();
          check("gnt_who", {30'd0, gnt_cpu, gnt_mon}, g.mon ? 32'd1 : 32'd2);
          if (g.gap != 0) check("gnt_gap", cyc - last_gnt, g.gap);
        end
        last_gnt = cyc;
        stb_cnt  = 0;
      end
      if (mem_stb) begin
        stb_cnt++;
        if (!prev_stb) begin
          if (wr_q.size() == 0) fail_now("unexpected_strobe");
          else begin
            w = wr_q.pop_front();
            check("mem_we", mem_we, w.we);
            if (w.we) check("mem_wdata", mem_wdata, w.wdata);
          end
        end
      end
      prev_stb = mem_stb;
      if (done_cpu || done_mon) begin
        if (done_q.size() == 0) fail_now("unexpected_done");
        else begin
          d = done_q.pop_front();
          $display("txn %s rdata=%h par=%0d tout=%0d aaddr=%o stb=%0d lat=%0d",
                   done_mon ? "MON" : "CPU", rdata, par_alarm, tout_alarm, alarm_addr, stb_cnt, cyc - last_gnt);
          check("done_who", {30'd0, done_cpu, done_mon}, d.mon ? 32'd1 : 32'd2);
          check("rdata", rdata, d.rdata);
          check("par_alarm", par_alarm, d.par);
          check("tout_alarm", tout_alarm, d.tout);
          check("alarm_addr", alarm_addr, d.aaddr);
          check("stb_cycles", stb_cnt, d.stb);
          check("latency", cyc - last_gnt, d.lat);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #400000;
    fail_now("watchdog");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit ok;
    // Reset, with a CPU request present that must not be granted.
    req_cpu = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    check("rst_gnt_cpu", gnt_cpu, 0);
    check("rst_wsg", wsg, 0);
    check("rst_stb", mem_stb, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_s", s_out, 0);
    check("rst_rdata", rdata, 0);
    check("rst_alarms", {par_alarm, tout_alarm}, 0);
    check("rst_aaddr", alarm_addr, 0);
    @(negedge clk);
    req_cpu = 1'b0;
    rst = 1'b0;

    // Reads: parity error then good parity.
    mem_rdata = 16'h8001;
    push_txn(0, 0, 16'h0, 0, 15'h0001, 1, 0, 12'o1234, 1, 3);
    issue(0, 12'o1234, 0, 15'h0, 0, 1);
    clear_alarms();
    mem_rdata = 16'h0001;
    push_txn(0, 0, 16'h0, 0, 15'h0001, 0, 0, 12'o0000, 1, 3);
    issue(0, 12'o0042, 0, 15'h0, 0, 1);
    check("s_out_hold", s_out, 12'o0042);

    // Writes: parity generation; RDATA keeps the last read.
    push_txn(0, 1, 16'h8000, 0, 15'h0001, 0, 0, 12'o0, 1, 3);
    issue(0, 12'o0100, 1, 15'h0000, 0, 1);
    push_txn(0, 1, 16'h0001, 0, 15'h0001, 0, 0, 12'o0, 1, 3);
    issue(0, 12'o0101, 1, 15'h0001, 0, 1);
    push_txn(0, 1, 16'h7fff, 0, 15'h0001, 0, 0, 12'o0, 1, 3);
    issue(0, 12'o0102, 1, 15'h7fff, 0, 1);
    push_txn(1, 1, 16'h8003, 0, 15'h0001, 0, 0, 12'o0, 1, 3);
    issue(1, 12'o0103, 1, 15'h0003, 0, 1);

    // Both requesters held: alternate CPU, MON, CPU, MON, four cycles apart.
    mem_rdata = 16'h0004;
    push_txn(0, 0, 16'h0, 0, 15'h0004, 0, 0, 12'o0, 1, 3);
    push_txn(1, 0, 16'h0, 4, 15'h0004, 0, 0, 12'o0, 1, 3);
    push_txn(0, 0, 16'h0, 4, 15'h0004, 0, 0, 12'o0, 1, 3);
    push_txn(1, 0, 16'h0, 4, 15'h0004, 0, 0, 12'o0, 1, 3);
    @(negedge clk);
    addr_cpu = 12'o0100; wr_cpu = 1'b0; wdata_cpu = '0;
    addr_mon = 12'o0200; wr_mon = 1'b0; wdata_mon = '0;
    req_cpu = 1'b1; req_mon = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      #4;
      if (gnt_cpu || gnt_mon) n++;
      @(negedge clk);
    end
    req_cpu = 1'b0; req_mon = 1'b0;
    if (n < 4) fail_now("alt_grants");
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #4;
      if (done_mon) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) fail_now("alt_done");

    // Timeout: no MEM_RDY at all.
    rdy_en = 1'b0;
    push_txn(0, 0, 16'h0, 0, 15'h0000, 0, 1, 12'o0055, 15, 17);
    issue(0, 12'o0055, 0, 15'h0, 0, 1);
    rdy_en = 1'b1;
    clear_alarms();

    // First alarm address is kept across a second failure.
    mem_rdata = 16'h0000;
    push_txn(0, 0, 16'h0, 0, 15'h0000, 1, 0, 12'o0010, 1, 3);
    issue(0, 12'o0010, 0, 15'h0, 0, 1);
    push_txn(0, 0, 16'h0, 0, 15'h0000, 1, 0, 12'o0010, 1, 3);
    issue(0, 12'o0020, 0, 15'h0, 0, 1);
    clear_alarms();
    // Clear coinciding with the second failure: the new alarm wins.
    push_txn(0, 0, 16'h0, 0, 15'h0000, 1, 0, 12'o0010, 1, 3);
    issue(0, 12'o0010, 0, 15'h0, 0, 1);
    push_txn(0, 0, 16'h0, 0, 15'h0000, 1, 0, 12'o0020, 1, 3);
    issue(0, 12'o0020, 1'b0, 15'h0, 1, 1);

    // Reset in the middle of a strobe: no DONE, everything back to zero.
    rdy_en = 1'b0;
    gnt_q.push_back('{mon: 1'b0, gap: 0});
    wr_q.push_back('{we: 1'b0, wdata: 16'h8000});
    issue(0, 12'o0300, 0, 15'h0, 0, 0);
    repeat (2) @(negedge clk);
    check("pre_rst_stb", mem_stb, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_stb", mem_stb, 0);
    check("arst_wsg", wsg, 0);
    check("arst_we", mem_we, 0);
    check("arst_s", s_out, 0);
    check("arst_par", par_alarm, 0);
    check("arst_aaddr", alarm_addr, 0);
    check("arst_done", {done_cpu, done_mon}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rdy_en = 1'b1;

    // After reset a tie goes to the CPU first.
    mem_rdata = 16'h0010;
    push_txn(0, 0, 16'h0, 0, 15'h0010, 0, 0, 12'o0, 1, 3);
    push_txn(1, 0, 16'h0, 4, 15'h0010, 0, 0, 12'o0, 1, 3);
    @(negedge clk);
    addr_cpu = 12'o0400; addr_mon = 12'o0500; wr_cpu = 1'b0; wr_mon = 1'b0;
    req_cpu = 1'b1; req_mon = 1'b1;
    n = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      #4;
      if (gnt_cpu || gnt_mon) n++;
      @(negedge clk);
    end
    req_cpu = 1'b0; req_mon = 1'b0;
    if (n < 2) fail_now("post_rst_grants");
    repeat (6) @(negedge clk);

    check("gnt_q_empty", gnt_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
